// File: rtl/sync_debounce_if.sv
// Level-input / debounced-output bundle for sync_debounce.
// The master side drives the sample strobe and raw levels; the slave returns the debounced level and edge pulses.
interface sync_debounce_if #(
   parameter int DW = 1
);
   logic          tick_i;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic [DW-1:0] rise_o;
   logic [DW-1:0] fall_o;

   modport master (
      output tick_i,
      output din,
      input  dout,
      input  rise_o,
      input  fall_o
   );

   modport slave (
      input  tick_i,
      input  din,
      output dout,
      output rise_o,
      output fall_o
   );
endinterface

// File: rtl/sync_debounce.sv
// Per-bit debouncer: a new input level is accepted after it has been seen on STABLE
// consecutive ticked edges; accepted transitions produce registered one-cycle rise/fall pulses.
module sync_debounce #(
   parameter int            DW      = 1,
   parameter int            STABLE  = 4,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   sync_debounce_if.slave  bus
);
   localparam int            CW   = $clog2(STABLE + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

   logic [DW-1:0] dout_q, dout_d;
   logic [DW-1:0] rise_q, rise_d;
   logic [DW-1:0] fall_q, fall_d;
   logic [CW-1:0] cnt_q [DW];
   logic [CW-1:0] cnt_d [DW];

   always_comb begin
      dout_d = dout_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < DW; i++) begin
         cnt_d[i] = cnt_q[i];
         // Any matching edge discards a partial count, so a reverting glitch leaves no trace.
         if (bus.din[i] == dout_q[i]) begin
            cnt_d[i] = '0;
         end else if (bus.tick_i) begin
            if (cnt_q[i] == LAST) begin
               cnt_d[i]  = '0;
               dout_d[i] = bus.din[i];
               rise_d[i] = bus.din[i];
               fall_d[i] = ~bus.din[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dout_q <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.dout   = dout_q;
   assign bus.rise_o = rise_q;
   assign bus.fall_o = fall_q;
endmodule
